eth_mac_swap: RTL and testbench

ETH_MAC_SWAP -- requirements
Module: eth_mac_swap

---
 rtl/eth_pkg.sv | 21 ++
 rtl/axis_reg_slice.sv | 38 +++
 rtl/eth_mac_swap.sv | 142 ++++++++++++++
 tb/tb_eth_mac_swap.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet header constants, the MAC-swap FSM state type and the
// header byte reordering helper.
package eth_pkg;

  localparam int HDR_LEN = 12;
  localparam int MAC_LEN = 6;

  typedef enum logic [1:0] {
    CAPTURE  = 2'd0,
    EMIT     = 2'd1,
    PASS     = 2'd2,
    DROPWAIT = 2'd3
  } state_e;

  // Buffer index that feeds output header byte idx: src MAC first, then dst MAC.
  function automatic logic [3:0] hdr_sel(input logic [3:0] idx, input logic swap);
    if (!swap || idx >= 4'(HDR_LEN)) return idx;
    return (idx < 4'(MAC_LEN)) ? idx + 4'(MAC_LEN) : idx - 4'(MAC_LEN);
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI4-Stream register slice; outputs come straight from flops,
// so there is no combinational path from m_tready to any m_* output.
module axis_reg_slice (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  input  logic       s_tuser,
  output logic       s_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  output logic       m_tuser,
  input  logic       m_tready
);

  assign s_tready = !m_tvalid || m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata  <= 8'h00;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else if (s_tready) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      m_tvalid <= s_tvalid;
      if (s_tvalid) begin
        m_tdata <= s_tdata;
        m_tlast <= s_tlast;
        m_tuser <= s_tuser;
      end
    end
  end

endmodule

// File: rtl/eth_mac_swap.sv
// Buffers the 12-byte Ethernet MAC header, re-emits it with destination and
// source swapped, then streams the payload through one register stage.
module eth_mac_swap
  import eth_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int SWAP_EN = 1
) (
  input  logic               gtx_clk,
  input  logic               gtx_resetn,
  input  logic [7:0]         rx_axis_tdata,
  input  logic               rx_axis_tvalid,
  input  logic               rx_axis_tlast,
  input  logic               rx_axis_tuser,
  output logic               rx_axis_tready,
  output logic [7:0]         tx_axis_tdata,
  output logic               tx_axis_tvalid,
  output logic               tx_axis_tlast,
  output logic               tx_axis_tuser,
  input  logic               tx_axis_tready,
  output logic [COUNT_W-1:0] frames_fwd,
  output logic [COUNT_W-1:0] frames_runt
);

  localparam logic [3:0]         LAST_IDX = 4'(HDR_LEN - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

  logic [1:0] rst_sync;
  logic       rst_n;
  state_e     state;
  logic [3:0] byte_idx;
  logic [7:0] hdr [HDR_LEN];
  logic       hdr_last;
  logic       hdr_user;
  logic       rx_rdy;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tuser, s_tready;

  // Assert asynchronously, release two gtx_clk edges after gtx_resetn rises.
  always_ff @(posedge gtx_clk or negedge gtx_resetn) begin
    if (!gtx_resetn) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    rx_rdy   = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    unique case (state)
      CAPTURE: rx_rdy = 1'b1;
      EMIT: begin
        s_tvalid = 1'b1;
        s_tdata  = hdr[hdr_sel(byte_idx, SWAP_EN != 0)];
        s_tlast  = hdr_last && (byte_idx == LAST_IDX);
        s_tuser  = hdr_user && (byte_idx == LAST_IDX);
      end
      PASS: begin
        s_tvalid = rx_axis_tvalid;
        s_tdata  = rx_axis_tdata;
        s_tlast  = rx_axis_tlast;
        s_tuser  = rx_axis_tuser;
        rx_rdy   = s_tready;
      end
      default: ;
    endcase
  end

  // State is forced to CAPTURE during reset, so the gate keeps tready low there.
  assign rx_axis_tready = rx_rdy && rst_n;

  always_ff @(posedge gtx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CAPTURE;
      byte_idx    <= 4'd0;
      hdr_last    <= 1'b0;
      hdr_user    <= 1'b0;
      frames_runt <= '0;
      // NOTE: the header buffer is deliberately cleared on reset so nothing
      // from an aborted frame can ever be re-emitted.
      for (int i = 0; i < HDR_LEN; i++) hdr[i] <= 8'h00;
    end else begin
      unique case (state)
        CAPTURE: if (rx_axis_tvalid) begin
          hdr[byte_idx] <= rx_axis_tdata;
          if (byte_idx == LAST_IDX) begin
            hdr_last <= rx_axis_tlast;
            hdr_user <= rx_axis_tuser;
            byte_idx <= 4'd0;
            state    <= EMIT;
          end else if (rx_axis_tlast) begin
            byte_idx <= 4'd0;
            if (frames_runt != CNT_MAX) frames_runt <= frames_runt + 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        EMIT: if (s_tready) begin
          if (byte_idx == LAST_IDX) begin
            byte_idx <= 4'd0;
            state    <= hdr_last ? CAPTURE : PASS;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        PASS: if (rx_axis_tvalid && s_tready && rx_axis_tlast) state <= CAPTURE;
        default: begin
          state    <= CAPTURE;
          byte_idx <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge gtx_clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_fwd <= '0;
    end else if (tx_axis_tvalid && tx_axis_tready && tx_axis_tlast && frames_fwd != CNT_MAX) begin
      frames_fwd <= frames_fwd + 1'b1;
    end
  end

  axis_reg_slice u_slice (
    .clk      (gtx_clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .s_tready (s_tready),
    .m_tdata  (tx_axis_tdata),
    .m_tvalid (tx_axis_tvalid),
    .m_tlast  (tx_axis_tlast),
    .m_tuser  (tx_axis_tuser),
    .m_tready (tx_axis_tready)
  );

endmodule

// File: tb/tb_eth_mac_swap.sv
// Scoreboard bench for eth_mac_swap: frames are turned into expected tx beats
// by a frame-level model; a monitor pops and compares every accepted tx beat.
module tb_eth_mac_swap;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic       last;
    logic       user;
    logic [7:0] data;
  } beat_t;

  logic        gtx_clk = 1'b0;
  logic        gtx_resetn;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid, rx_tlast, rx_tuser;
  logic        rx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid, tx_tlast, tx_tuser;
  logic        tx_tready;
  logic [15:0] frames_fwd, frames_runt;

  logic        sat_rx_tready;
  logic [7:0]  sat_tx_tdata;
  logic        sat_tx_tvalid, sat_tx_tlast, sat_tx_tuser;
  logic [1:0]  sat_fwd, sat_runt;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  int    exp_fwd = 0;
  int    exp_runt = 0;
  int    rdy_mode = 0;
  int    pat = 0;
  bit    gap_en = 0;

  always #4 gtx_clk = ~gtx_clk;

  eth_mac_swap dut (
    .gtx_clk(gtx_clk), .gtx_resetn(gtx_resetn),
    .rx_axis_tdata(rx_tdata), .rx_axis_tvalid(rx_tvalid), .rx_axis_tlast(rx_tlast),
    .rx_axis_tuser(rx_tuser), .rx_axis_tready(rx_tready),
    .tx_axis_tdata(tx_tdata), .tx_axis_tvalid(tx_tvalid), .tx_axis_tlast(tx_tlast),
    .tx_axis_tuser(tx_tuser), .tx_axis_tready(tx_tready),
    .frames_fwd(frames_fwd), .frames_runt(frames_runt)
  );

  eth_mac_swap #(.COUNT_W(2)) dut_sat (
    .gtx_clk(gtx_clk), .gtx_resetn(gtx_resetn),
    .rx_axis_tdata(rx_tdata), .rx_axis_tvalid(rx_tvalid), .rx_axis_tlast(rx_tlast),
    .rx_axis_tuser(rx_tuser), .rx_axis_tready(sat_rx_tready),
    .tx_axis_tdata(sat_tx_tdata), .tx_axis_tvalid(sat_tx_tvalid), .tx_axis_tlast(sat_tx_tlast),
    .tx_axis_tuser(sat_tx_tuser), .tx_axis_tready(tx_tready),
    .frames_fwd(sat_fwd), .frames_runt(sat_runt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: runts vanish, otherwise the two MACs trade places.
  task automatic model_frame(input byte_q_t fr, input logic user);
    int n = fr.size();
    beat_t b;
    if (n < 12) begin
      exp_runt++;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (k < 6)       b.data = fr[k + 6];
      else if (k < 12) b.data = fr[k - 6];
      else             b.data = fr[k];
      b.last = (k == n - 1);
      b.user = (k == n - 1) ? user : 1'b0;
      exp_q.push_back(b);
    end
    exp_fwd++;
  endtask

  function automatic byte_q_t mk_frame(input int len, input logic [47:0] dst, input logic [47:0] src);
    byte_q_t fr;
    logic [95:0] mac;
    mac = {dst, src};
    for (int i = 0; i < len; i++) begin
      if (i < 12) fr.push_back(mac[95 - 8*i -: 8]);
      else        fr.push_back(8'($urandom));
    end
    return fr;
  endfunction

  // Called and returns at posedge+1; stop_at >= 0 abandons the frame after that many bytes.
  task automatic send_frame(input byte_q_t fr, input logic user, input int stop_at);
    bit acc;
    int n;
    model_frame(fr, user);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == stop_at) break;
      if (gap_en) begin
        while ($urandom_range(3) == 0) begin
          rx_tvalid = 1'b0;
          @(posedge gtx_clk); #1;
        end
      end
      rx_tdata  = fr[i];
      rx_tvalid = 1'b1;
      rx_tlast  = (i == fr.size() - 1);
      rx_tuser  = (i == fr.size() - 1) ? user : 1'b0;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 1000) begin
        @(negedge gtx_clk);
        acc = rx_tready;
        @(posedge gtx_clk); #1;
        n++;
      end
      if (!acc) begin
        check("rx_accept_timeout", 32'(acc), 32'd1);
        break;
      end
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge gtx_clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge gtx_clk);
    @(posedge gtx_clk); #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_fwd"}, 32'(frames_fwd), 32'(exp_fwd));
    check({tag, "_runt"}, 32'(frames_runt), 32'(exp_runt));
    check({tag, "_runt_sat"}, 32'(sat_runt), (exp_runt > 3) ? 32'd3 : 32'(exp_runt));
  endtask

  // tx_tready driver; changes land 2 units after the edge.
  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge gtx_clk); #2;
      case (rdy_mode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = 1'($urandom_range(1));
        2:       begin tx_tready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
        default: tx_tready = 1'b0;
      endcase
    end
  end

  // Monitor: a beat transfers at the next rising edge when valid && ready now.
  initial begin
    beat_t e;
    forever begin
      @(negedge gtx_clk);
      if (gtx_resetn && tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          check("tx_extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("tx_beat", {22'd0, tx_tlast, tx_tuser, tx_tdata}, {22'd0, e.last, e.user, e.data});
        end
      end
    end
  end

  initial begin
    byte_q_t fr;
    gtx_resetn = 1'b0;
    rx_tdata = 8'h00; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    repeat (3) @(posedge gtx_clk); #1;

    check("rst_rx_tready", 32'(rx_tready), 32'd0);
    check("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
    check("rst_tx_tdata", {22'd0, tx_tlast, tx_tuser, tx_tdata}, 32'd0);
    check_counts("rst");
    gtx_resetn = 1'b1;
    check("sync_rx_tready", 32'(rx_tready), 32'd0);
    repeat (3) @(posedge gtx_clk); #1;
    check("post_rst_rx_tready", 32'(rx_tready), 32'd1);

    // 64-byte frame with fixed MACs, no stalls.
    fr = mk_frame(64, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02);
    send_frame(fr, 1'b0, -1);
    wait_drain();
    check_counts("f64");

    // 8-byte runt then a 60-byte frame.
    fr = mk_frame(8, 48'h0A_0B_0C_0D_0E_0F, 48'h10_11_12_13_14_15);
    send_frame(fr, 1'b0, -1);
    fr = mk_frame(60, 48'($urandom) << 16 | 48'($urandom), 48'h66_77_88_99_AA_BB);
    send_frame(fr, 1'b0, -1);
    wait_drain();
    check_counts("runt8");

    // Header-only frame flagged bad.
    fr = mk_frame(12, 48'hAA_BB_CC_DD_EE_FF, 48'h11_22_33_44_55_66);
    send_frame(fr, 1'b1, -1);
    wait_drain();
    check_counts("hdr_only");

    // 100-byte frame with tx_tready cycling 1,0,0,1.
    rdy_mode = 2; pat = 0;
    fr = mk_frame(100, 48'h00_01_02_03_04_05, 48'h06_07_08_09_0A_0B);
    send_frame(fr, 1'b0, -1);
    wait_drain();
    rdy_mode = 0;
    check_counts("stall");

    // Runts at the boundary lengths; pushes the 2-bit counter into saturation.
    foreach (fr[i]) fr[i] = 8'h00;
    for (int r = 0; r < 5; r++) begin
      fr = mk_frame((r == 0) ? 11 : (r == 1) ? 1 : $urandom_range(2, 10), 48'h1, 48'h2);
      send_frame(fr, 1'b0, -1);
    end
    wait_drain();
    check_counts("runt_burst");

    // Runt arriving while the previous frame's last beat is stuck on tx.
    fr = mk_frame(20, 48'h12_34_56_78_9A_BC, 48'hDE_F0_12_34_56_78);
    send_frame(fr, 1'b0, -1);
    rdy_mode = 3;
    fr = mk_frame(5, 48'h3, 48'h4);
    send_frame(fr, 1'b0, -1);
    @(posedge gtx_clk); #1;
    check("pend_tvalid", 32'(tx_tvalid), 32'd1);
    check("pend_runt", 32'(frames_runt), 32'(exp_runt));
    rdy_mode = 0;
    wait_drain();
    check_counts("pend");

    // Randomized frames, gaps and back-pressure.
    rdy_mode = 1; gap_en = 1;
    for (int f = 0; f < 24; f++) begin
      fr = mk_frame(($urandom_range(3) == 0) ? $urandom_range(1, 13) : $urandom_range(12, 80),
                    {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)});
      send_frame(fr, 1'($urandom_range(1)), -1);
    end
    wait_drain();
    rdy_mode = 0; gap_en = 0;
    check_counts("random");

    // Reset pulsed after 30 bytes of a 64-byte frame.
    fr = mk_frame(64, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02);
    send_frame(fr, 1'b0, 30);
    gtx_resetn = 1'b0;
    #1;
    check("mid_rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
    check("mid_rst_rx_tready", 32'(rx_tready), 32'd0);
    exp_q.delete();
    exp_fwd = 0;
    exp_runt = 0;
    repeat (2) @(posedge gtx_clk); #1;
    gtx_resetn = 1'b1;
    fr = mk_frame(64, 48'h02_00_00_00_00_03, 48'h02_00_00_00_00_04);
    send_frame(fr, 1'b0, -1);
    wait_drain();
    check_counts("after_rst");

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
